// File: rtl/step_ctrl_pkg.sv
// Shared constants for the step controller: FSM state encoding and default timing.
package step_ctrl_pkg;

  localparam int CNT_W = 23;

  localparam logic [CNT_W-1:0] HOLD_CYCLES_DEFAULT   = 23'd2500000;
  localparam logic [CNT_W-1:0] REPEAT_CYCLES_DEFAULT = 23'd1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; the history register resets to 1 so a level already
// high when reset releases is not treated as a fresh press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= in;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/step_ctrl.sv
// Single-step / auto-repeat / free-run clock-enable generator for a processor,
// driven by a debounced step button and a run/step switch.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic        run_mode,
  output logic        step_en,
  output logic [15:0] step_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_en_q, step_en_d;
  logic [15:0]        step_count_q, step_count_d;
  logic               btn_rise;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .in    (btn),
    .rise  (btn_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      step_en_q    <= 1'b0;
      step_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_en_q    <= step_en_d;
      step_count_q <= step_count_d;
    end
  end

  // Free run overrides the step FSM entirely and parks it in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_en_d = 1'b0;
    if (run_mode) begin
      state_d   = IDLE;
      cnt_d     = '0;
      step_en_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_rise) begin
            step_en_d = 1'b1;
            state_d   = HOLD;
            cnt_d     = '0;
          end
        end
        HOLD: begin
          if (!btn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_CYCLES - 23'd1) begin
            step_en_d = 1'b1;
            state_d   = REPEAT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 23'd1;
          end
        end
        REPEAT: begin
          if (!btn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == REPEAT_CYCLES - 23'd1) begin
            step_en_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 23'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Counts every cycle step_en is high, including the one being registered now.
  always_comb begin
    step_count_d = step_count_q;
    if (step_en_d) step_count_d = step_count_q + 16'd1;
  end

  assign step_en    = step_en_q;
  assign step_count = step_count_q;

endmodule
